mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_LEN, default 32, data/address width.
REQ-002 Parameter MEM_LATENCY, default 1, legal 1..4, cycles from mem_addr presentation to mem_rdata valid.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  input  1  instruction fetch request.
REQ-006 i_req_ready  output  1  fetch request accepted this cycle when high with i_req_valid.
REQ-007 i_addr  input  WORD_LEN  fetch address.
REQ-008 i_resp_valid  output  1  one-cycle pulse, i_rdata valid.
REQ-009 i_rdata  output  WORD_LEN  fetched instruction.
REQ-010 d_req_valid / d_req_ready  input / output  1 each  data request handshake.
REQ-011 d_addr, d_wdata  input  WORD_LEN each; d_wen  input  1  (1 = store).
REQ-012 d_resp_valid  output  1; d_rdata  output  WORD_LEN.
REQ-013 mem_addr, mem_wdata  output  WORD_LEN; mem_wen  output  1; mem_rdata  input  WORD_LEN  shared single-port memory.

Function
REQ-014 FSM states IDLE, WAIT, RESP; handshake only in IDLE.
REQ-015 i_req_ready = d_req_ready = (state==IDLE), decoded from state only, independent of any valid.
REQ-016 IDLE, no valid: stay IDLE; one valid: grant it; both valid: arbitrate per REQ-027/028.
REQ-017 On grant (cycle T): latch addr, wdata, wen, grant-owner; -> WAIT with counter = MEM_LATENCY-1.
REQ-018 WAIT occupies cycles T+1..T+MEM_LATENCY; mem_addr/mem_wdata held from latches throughout.
REQ-019 mem_wen high only in cycle T+1, only for granted store; never for fetches.
REQ-020 Last WAIT cycle (counter==0): capture mem_rdata (loads/fetches) or 0 (stores); -> RESP.
REQ-021 RESP (cycle T+MEM_LATENCY+1): owner's resp_valid high exactly one cycle with captured data; other resp_valid low; -> IDLE.
REQ-022 Handshake-to-response latency = MEM_LATENCY+1 cycles; slot occupancy MEM_LATENCY+2 cycles; one outstanding request max.
REQ-023 i_rdata/d_rdata hold last captured value when resp_valid low.
REQ-024 Non-granted requester sees ready only while IDLE; requester holds valid/address until accepted.
REQ-025 Request valid changes outside IDLE ignored; no queuing.

Reset
REQ-026 rst_n low, any cycle incl. mid-WAIT/RESP: state=IDLE, counter=0, all outputs 0 except readies (1 after state settles IDLE), last_grant=I; outstanding request discarded with no response pulse.

Configuration
REQ-027 MEM_ARBITER_RR_EN undefined: fixed priority, d wins every simultaneous request.
REQ-028 MEM_ARBITER_RR_EN defined: round-robin; register last_grant updated on every grant; simultaneous request goes to the port not last granted; after reset d wins first tie.

Verification
REQ-029 MEM_LATENCY=1, i_req_valid only, i_addr=0x10, mem returns 0x00000013 -> i_req_ready=1 at T, i_resp_valid at T+2 with i_rdata=0x00000013, d_resp_valid stays 0.
REQ-030 d store d_addr=0x100, d_wdata=0xDEADBEEF -> mem_wen=1 for exactly cycle T+1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; d_resp_valid at T+2, d_rdata=0.
REQ-031 Both valid held 4 grants, no macro -> d granted every IDLE; i never granted while d_req_valid=1.
REQ-032 Both valid held 4 grants, MEM_ARBITER_RR_EN -> order d, i, d, i; grants spaced 3 cycles apart.
REQ-033 MEM_LATENCY=3, d load 0x200 -> readies low cycles T+1..T+4, d_resp_valid at T+4 with mem_rdata sampled at T+3.
REQ-034 rst_n pulsed low at T+1 of pending fetch -> no i_resp_valid ever for it, state IDLE, readies 1 after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one single-port memory, one request in flight.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module mem_arbiter #(
  parameter int WORD_LEN    = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  input  logic                d_wen,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic                mem_wen,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);
  localparam logic [WORD_LEN-1:0] ZERO_W = {WORD_LEN{1'b0}};

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                grant_s;
  logic                grant_d_s;
  logic                capture_s;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic                wen_q;
  logic                owner_q;
  logic                mem_wen_q;
  logic                i_resp_q;
  logic                d_resp_q;
  logic [WORD_LEN-1:0] i_rdata_q;
  logic [WORD_LEN-1:0] d_rdata_q;

  assign grant_s   = (state_q == ST_IDLE) & (i_req_valid | d_req_valid);
  assign capture_s = (state_q == ST_WAIT) & (cnt_q == 2'd0);

`ifdef MEM_ARBITER_RR_EN
  logic last_grant_q;

  // Tie goes to whichever port was not granted last; reset value favours the data port.
  always_comb begin
    grant_d_s = d_req_valid & (~i_req_valid | ~last_grant_q);
  end

  // Remember the owner of every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else if (grant_s) begin
      last_grant_q <= grant_d_s;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end
`else
  assign grant_d_s = d_req_valid;
`endif

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Readies depend on state alone so a requester can never create a combinational loop.
  always_comb begin
    i_req_ready = (state_q == ST_IDLE);
    d_req_ready = (state_q == ST_IDLE);
  end

  // Request latches, write strobe and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= ZERO_W;
      wdata_q   <= ZERO_W;
      wen_q     <= 1'b0;
      owner_q   <= 1'b0;
      mem_wen_q <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= ZERO_W;
      d_rdata_q <= ZERO_W;
    end else begin
      if (grant_s) begin
        addr_q  <= grant_d_s ? d_addr : i_addr;
        wdata_q <= grant_d_s ? d_wdata : ZERO_W;
        wen_q   <= grant_d_s & d_wen;
        owner_q <= grant_d_s;
      end else begin
        addr_q  <= addr_q;
        wdata_q <= wdata_q;
        wen_q   <= wen_q;
        owner_q <= owner_q;
      end
      // Strobe lasts only the first WAIT cycle.
      mem_wen_q <= grant_s & grant_d_s & d_wen;
      i_resp_q  <= capture_s & ~owner_q;
      d_resp_q  <= capture_s & owner_q;
      if (capture_s && !owner_q) begin
        i_rdata_q <= mem_rdata;
      end else begin
        i_rdata_q <= i_rdata_q;
      end
      if (capture_s && owner_q) begin
        d_rdata_q <= wen_q ? ZERO_W : mem_rdata;
      end else begin
        d_rdata_q <= d_rdata_q;
      end
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wen      = mem_wen_q;
  assign i_resp_valid = i_resp_q;
  assign d_resp_valid = d_resp_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3, shared request inputs.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic [31:0] i_addr;
  logic        d_req_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_wen;

  logic        u1_i_ready, u1_i_resp, u1_d_ready, u1_d_resp, u1_mem_wen;
  logic [31:0] u1_i_rdata, u1_d_rdata, u1_mem_addr, u1_mem_wdata, mem1_rdata;
  logic        u3_i_ready, u3_i_resp, u3_d_ready, u3_d_resp, u3_mem_wen;
  logic [31:0] u3_i_rdata, u3_d_rdata, u3_mem_addr, u3_mem_wdata, mem3_rdata;

  int err_cnt;
  int chk_cnt;

  // Latency-1 memory model: data = address + 3.
  assign mem1_rdata = u1_mem_addr + 32'h0000_0003;

  mem_arbiter #(.WORD_LEN(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(u1_i_ready), .i_addr(i_addr),
    .i_resp_valid(u1_i_resp), .i_rdata(u1_i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(u1_d_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wen(d_wen), .d_resp_valid(u1_d_resp), .d_rdata(u1_d_rdata),
    .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_wen(u1_mem_wen),
    .mem_rdata(mem1_rdata)
  );

  mem_arbiter #(.WORD_LEN(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(u3_i_ready), .i_addr(i_addr),
    .i_resp_valid(u3_i_resp), .i_rdata(u3_i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(u3_d_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wen(d_wen), .d_resp_valid(u3_d_resp), .d_rdata(u3_d_rdata),
    .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata), .mem_wen(u3_mem_wen),
    .mem_rdata(mem3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    d_wen       = 1'b0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic exp_d;
    err_cnt     = 0;
    chk_cnt     = 0;
    i_addr      = 32'h0;
    d_addr      = 32'h0;
    d_wdata     = 32'h0;
    mem3_rdata  = 32'h0;
    do_reset();

    // Reset state
    check_eq("rst_i_ready", {31'd0, u1_i_ready}, 32'd1);
    check_eq("rst_d_ready", {31'd0, u1_d_ready}, 32'd1);
    check_eq("rst_resp", {30'd0, u1_i_resp, u1_d_resp}, 32'd0);
    check_eq("rst_mem_addr", u1_mem_addr, 32'h0);
    check_eq("rst_mem_wen", {31'd0, u1_mem_wen}, 32'd0);

    // Fetch, latency 1
    i_req_valid = 1'b1;
    i_addr      = 32'h0000_0010;
    check_eq("f_ready_T", {31'd0, u1_i_ready}, 32'd1);
    step();
    i_req_valid = 1'b0;
    check_eq("f_ready_T1", {31'd0, u1_i_ready}, 32'd0);
    check_eq("f_mem_addr", u1_mem_addr, 32'h0000_0010);
    check_eq("f_no_wen", {31'd0, u1_mem_wen}, 32'd0);
    check_eq("f_no_resp_T1", {31'd0, u1_i_resp}, 32'd0);
    step();
    check_eq("f_resp_T2", {31'd0, u1_i_resp}, 32'd1);
    check_eq("f_rdata", u1_i_rdata, 32'h0000_0013);
    check_eq("f_d_resp", {31'd0, u1_d_resp}, 32'd0);
    step();
    check_eq("f_resp_drop", {31'd0, u1_i_resp}, 32'd0);
    check_eq("f_rdata_hold", u1_i_rdata, 32'h0000_0013);
    check_eq("f_ready_back", {31'd0, u1_i_ready}, 32'd1);

    // Store, latency 1
    d_req_valid = 1'b1;
    d_wen       = 1'b1;
    d_addr      = 32'h0000_0100;
    d_wdata     = 32'hDEAD_BEEF;
    step();
    d_req_valid = 1'b0;
    d_wen       = 1'b0;
    check_eq("s_wen_T1", {31'd0, u1_mem_wen}, 32'd1);
    check_eq("s_addr", u1_mem_addr, 32'h0000_0100);
    check_eq("s_wdata", u1_mem_wdata, 32'hDEAD_BEEF);
    step();
    check_eq("s_wen_T2", {31'd0, u1_mem_wen}, 32'd0);
    check_eq("s_resp", {31'd0, u1_d_resp}, 32'd1);
    check_eq("s_rdata", u1_d_rdata, 32'h0);
    check_eq("s_i_resp", {31'd0, u1_i_resp}, 32'd0);
    step();
    check_eq("s_resp_drop", {31'd0, u1_d_resp}, 32'd0);

    // Simultaneous requests held for four grants
    do_reset();
    i_addr      = 32'h0000_0020;
    d_addr      = 32'h0000_0030;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check_eq("t_ready", {31'd0, u1_d_ready}, 32'd1);
      step();
      check_eq("t_busy", {31'd0, u1_i_ready}, 32'd0);
      check_eq("t_addr", u1_mem_addr, exp_d ? 32'h0000_0030 : 32'h0000_0020);
      step();
      check_eq("t_d_resp", {31'd0, u1_d_resp}, {31'd0, exp_d});
      check_eq("t_i_resp", {31'd0, u1_i_resp}, {31'd0, ~exp_d});
      step();
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;

    // Load, latency 3: data sampled in the last WAIT cycle
    do_reset();
    d_req_valid = 1'b1;
    d_wen       = 1'b0;
    d_addr      = 32'h0000_0200;
    mem3_rdata  = 32'h1111_1111;
    check_eq("l3_ready_T", {31'd0, u3_d_ready}, 32'd1);
    step();
    d_req_valid = 1'b0;
    mem3_rdata  = 32'h2222_2222;
    check_eq("l3_ready_T1", {30'd0, u3_i_ready, u3_d_ready}, 32'd0);
    check_eq("l3_addr", u3_mem_addr, 32'h0000_0200);
    step();
    mem3_rdata = 32'h3333_3333;
    check_eq("l3_ready_T2", {30'd0, u3_i_ready, u3_d_ready}, 32'd0);
    check_eq("l3_resp_T2", {31'd0, u3_d_resp}, 32'd0);
    step();
    mem3_rdata = 32'h4444_4444;
    check_eq("l3_ready_T3", {30'd0, u3_i_ready, u3_d_ready}, 32'd0);
    check_eq("l3_resp_T3", {31'd0, u3_d_resp}, 32'd0);
    step();
    mem3_rdata = 32'h5555_5555;
    check_eq("l3_ready_T4", {30'd0, u3_i_ready, u3_d_ready}, 32'd0);
    check_eq("l3_resp_T4", {31'd0, u3_d_resp}, 32'd1);
    check_eq("l3_rdata", u3_d_rdata, 32'h4444_4444);
    check_eq("l3_i_resp", {31'd0, u3_i_resp}, 32'd0);
    step();
    check_eq("l3_ready_T5", {31'd0, u3_d_ready}, 32'd1);
    check_eq("l3_resp_T5", {31'd0, u3_d_resp}, 32'd0);
    check_eq("l3_rdata_hold", u3_d_rdata, 32'h4444_4444);

    // Reset in the middle of a pending fetch
    do_reset();
    i_req_valid = 1'b1;
    i_addr      = 32'h0000_0010;
    step();
    i_req_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_eq("r_ready_in_rst", {31'd0, u1_i_ready}, 32'd1);
    check_eq("r_addr_in_rst", u1_mem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_eq("r_no_resp", {31'd0, u1_i_resp}, 32'd0);
      check_eq("r_ready", {31'd0, u1_i_ready}, 32'd1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
